// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared constants, op codes and sequencer state encoding for the ALU
//          shift path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SAR  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_shift.sv
// ============================================================================
// Module : alu_shift
// Brief  : Single-step 16-bit shifter (one bit per op), combinational.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shift
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    // carry is the bit that falls off the end for this single step
    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            OP_SAR: begin
                result = {a[WIDTH-1], a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: begin
                result = a;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_shift_seq.sv
// ============================================================================
// Module : alu_shift_seq
// Brief  : Multi-cycle shift sequencer iterating alu_shift once per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shift_seq
    import alu_pkg::seq_state_t, alu_pkg::IDLE, alu_pkg::SHIFT, alu_pkg::DONE,
           alu_pkg::OP_PASS;
#(
    parameter int WIDTH = 16,   // fixed by alu_shift; no other value is legal
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             busy
);

    seq_state_t       state;
    seq_state_t       state_nx;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] count;
    logic [1:0]       op_q;
    logic             carry;

    logic [WIDTH-1:0] step_result;
    logic             step_carry;

    alu_shift u_step (
        .a      (work),
        .op     (op_q),
        .result (step_result),
        .carry  (step_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs decode from state only, so nothing on in_* reaches out_*.
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_result = '0;
        out_carry  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_amt == '0 || in_op == OP_PASS) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == AMT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_result = work;
                out_carry  = carry;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            count <= '0;
            op_q  <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_a;
                        op_q  <= in_op;
                        count <= in_amt;
                        carry <= 1'b0;
                    end
                end
                SHIFT: begin
                    work  <= step_result;
                    carry <= step_carry;
                    count <= count - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_seq.sv
// ============================================================================
// Module : tb_alu_shift_seq
// Brief  : Self-checking bench for alu_shift_seq with a reference shift model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [1:0]  in_op;
    logic [3:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_carry;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_shift_seq #(.WIDTH(16), .AMT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_op      (in_op),
        .in_amt     (in_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-amount shift computed directly with arithmetic operators.
    function automatic void model(input logic [15:0] a, input logic [1:0] op,
                                  input logic [3:0] amt,
                                  output logic [15:0] r, output logic c);
        int n;
        logic [15:0] t;
        n = int'(amt);
        r = a;
        c = 1'b0;
        if (op == 2'b11 || n == 0) return;
        case (op)
            2'b00: begin
                r = a << n;
                t = a >> (16 - n);
                c = t[0];
            end
            2'b01: begin
                r = a >> n;
                t = a >> (n - 1);
                c = t[0];
            end
            default: begin
                r = $signed(a) >>> n;
                t = $signed(a) >>> (n - 1);
                c = t[0];
            end
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic send(input logic [15:0] a, input logic [1:0] op,
                        input logic [3:0] amt, input int stall);
        logic [15:0] er;
        logic        ec;
        int          el;
        int          lat;
        model(a, op, amt, er, ec);
        el = (op == 2'b11 || amt == 4'd0) ? 0 : int'(amt);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_op     = op;
        in_amt    = amt;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk("busy_shift", 32'(busy), 32'd1);
            chk("in_ready_shift", 32'(in_ready), 32'd0);
            in_valid = 1'($urandom);
            in_a     = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'(el));
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("result", 32'(out_result), 32'(er));
        chk("carry", 32'(out_carry), 32'(ec));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_a     = 16'($urandom);
            in_op    = 2'($urandom);
            in_amt   = 4'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", 32'(out_result), 32'(er));
            chk("stall_carry", 32'(out_carry), 32'(ec));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_op     = '0;
        in_amt    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        send(16'h0001, 2'b00, 4'd4, 0);
        send(16'h8001, 2'b01, 4'd1, 0);
        send(16'h8000, 2'b10, 4'd15, 0);
        send(16'hFFFF, 2'b00, 4'd15, 0);
        send(16'h1234, 2'b11, 4'd7, 0);
        send(16'hABCD, 2'b00, 4'd0, 0);
        send(16'h5A5A, 2'b01, 4'd3, 5);

        // Asynchronous reset in the middle of a SAR
        in_valid = 1'b1;
        in_a     = 16'h8421;
        in_op    = 2'b10;
        in_amt   = 4'd10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(out_result), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("no_result_after_abort", 32'(out_valid), 32'd0);
        end
        send(16'h00F0, 2'b00, 4'd2, 0);

        for (int k = 0; k < 1000; k++) begin
            send(16'($urandom), 2'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
